// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: per-channel word buffers with round-robin grant driving a generic N-to-1 mux
module mux_rr_feeder #(
  parameter int N = 4,
  parameter int M = 8,
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  input  logic [N-1:0][M-1:0]   req_data,
  output logic [N-1:0]          req_ready,
  output logic [N-1:0][M-1:0]   data,
  output logic [SEL_W-1:0]      select,
  output logic                  enable,
  output logic                  out_valid,
  input  logic                  out_ready
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [N-1:0] f;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic found;
  int d;
  int best;
  assign req_ready = ~f;
  assign out_valid = enable;
  assign push = req_valid & ~f;
  // pick the full channel nearest after ptr; only real channel indices are ever produced
  always_comb begin
    idx = '0;
    found = 1'b0;
    best = N;
    d = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + 2 * N - int'(ptr) - 1) % N;
      if (f[i] && d < best) begin
        best = d;
        idx = SEL_W'(i);
        found = 1'b1;
      end
    end
  end
  // one-hot of the channel being consumed on this edge
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop[i] = (state == GRANT) && out_ready && (select == SEL_W'(i));
  end
  // buffers: capture on push, empty on pop; the granted channel is full so never pushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f <= '0;
      data <= '0;
    end else begin
      f <= (f & ~pop) | push;
      for (int i = 0; i < N; i++) if (push[i]) data[i] <= req_data[i];
    end
  end
  // grant FSM: register a selection in IDLE, hold it in GRANT until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      select <= '0;
      enable <= 1'b0;
      ptr <= SEL_W'(N - 1);
    end else if (state == IDLE) begin
      if (found) begin
        select <= idx;
        enable <= 1'b1;
        state <= GRANT;
      end
    end else if (out_ready) begin
      ptr <= select;
      enable <= 1'b0;
      state <= IDLE;
    end
  end
endmodule
